// File: rtl/fifo_ser_pkg.sv
// Shared types for the FIFO-to-serial bit serializer.
package fifo_ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT
  } ser_state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/fifo_bit_serializer.sv
// Pops WIDTH-bit words from a registered-read FIFO and shifts them out MSB-first
// on a valid/ready serial port. Define SER_PARITY_EN to append an even-parity beat.
module fifo_bit_serializer
  import fifo_ser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_data,
  output logic             ser_last,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

  ser_state_t       state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             at_last;
  logic             cur_bit;

`ifdef SER_PARITY_EN
  logic parity_reg, parity_next;

  // Parity is latched with the word so it survives the shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_reg <= 1'b0;
    end else begin
      parity_reg <= parity_next;
    end
  end

  always_comb begin
    parity_next = parity_reg;
    if (state_reg == FETCH) begin
      parity_next = ^fifo_data;
    end
  end

  assign cur_bit = (count_reg == LAST_CNT) ? parity_reg : shreg_reg[WIDTH-1];
`else
  assign cur_bit = shreg_reg[WIDTH-1];
`endif

  assign at_last = (count_reg == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    count_next = count_reg;
    fifo_rd_en = 1'b0;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    ser_last   = 1'b0;
    busy       = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (!fifo_empty && !reset) begin
          fifo_rd_en = 1'b1;
          state_next = FETCH;
        end
      end

      FETCH: begin
        // Read data arrives one cycle after the pop strobe.
        shreg_next = fifo_data;
        count_next = '0;
        state_next = SHIFT;
      end

      SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = cur_bit;
        ser_last  = at_last;
        if (ser_ready) begin
          shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
          if (at_last) begin
            // Prefetch the next word so the inter-word gap is the FETCH cycle only.
            if (!fifo_empty && !reset) begin
              fifo_rd_en = 1'b1;
              state_next = FETCH;
            end else begin
              state_next = IDLE;
            end
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_bit_serializer.sv
// Self-checking bench for fifo_bit_serializer with a behavioural registered-read FIFO.
// Bit-level expectations come from a scoreboard queue filled when words are pushed.
module tb_fifo_bit_serializer;
  import fifo_ser_pkg::*;

  localparam int WIDTH = DEFAULT_WIDTH;
`ifdef SER_PARITY_EN
  localparam int BEATS = WIDTH + 1;
`else
  localparam int BEATS = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             ser_ready;
  logic             ser_valid;
  logic             ser_data;
  logic             ser_last;
  logic             busy;

  always #5 clk = ~clk;

  fifo_bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .ser_ready  (ser_ready),
    .ser_valid  (ser_valid),
    .ser_data   (ser_data),
    .ser_last   (ser_last),
    .busy       (busy)
  );

  // Upstream FIFO model: one-cycle registered read.
  logic [WIDTH-1:0] mem [0:63];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_cnt % 64];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  typedef struct packed {
    logic data;
    logic last;
  } beat_t;

  beat_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    mem[wr_cnt % 64] = w;
    wr_cnt++;
    for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef SER_PARITY_EN
      exp_q.push_back('{data: w[i], last: 1'b0});
`else
      exp_q.push_back('{data: w[i], last: (i == 0)});
`endif
    end
`ifdef SER_PARITY_EN
    exp_q.push_back('{data: ^w, last: 1'b1});
`endif
    $display("push word %08h (%0d beats expected)", w, BEATS);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  int   hs_cnt     = 0;
  int   rd_pulses  = 0;
  int   rd_at_last = 0;
  int   last_seen  = 0;
  int   gap_cnt    = 0;
  int   last_gap   = -1;
  logic prev_rd    = 1'b0;
  logic prev_stall = 1'b0;
  logic prev_bit   = 1'b0;
  logic in_gap     = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_rd    = 1'b0;
      prev_stall = 1'b0;
      in_gap     = 1'b0;
    end else begin
      if (fifo_rd_en) rd_pulses++;
      if (prev_rd) check("rd_en_back_to_back", {31'd0, fifo_rd_en}, 32'd0);
      if (prev_stall) begin
        check("stall_valid", {31'd0, ser_valid}, 32'd1);
        check("stall_data", {31'd0, ser_data}, {31'd0, prev_bit});
      end
      if (in_gap) begin
        if (!ser_valid) begin
          gap_cnt++;
        end else begin
          last_gap = gap_cnt;
          in_gap   = 1'b0;
        end
      end
      if (ser_valid && ser_ready) begin
        beat_t e;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ser_data", {31'd0, ser_data}, {31'd0, e.data});
          check("ser_last", {31'd0, ser_last}, {31'd0, e.last});
        end
        if (ser_last) begin
          last_seen++;
          if (fifo_rd_en) rd_at_last++;
          in_gap  = 1'b1;
          gap_cnt = 0;
        end
      end
      prev_rd    = fifo_rd_en;
      prev_stall = ser_valid && !ser_ready;
      prev_bit   = ser_data;
    end
  end

  // Advances one cycle at a time, driving ser_ready per mode, until target handshakes.
  int phase = 0;
  task automatic wait_hs(input int target, input int mode, input int budget);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      @(posedge clk);
      #1;
      ser_ready = (mode == 0) ? 1'b1 : ((phase % 4 == 0) || (phase % 4 == 3));
      phase++;
      n++;
    end
    check("handshake_count", hs_cnt, target);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || !fifo_empty) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_valid", {31'd0, ser_valid}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          nwords;
    int          mode;
    int          exp_hs;
    int          exp_rd;
    int          exp_lasts;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int base_hs, base_rd, base_ral, base_last;

    tbl[0] = '{32'h8000_0001, 32'h0, 1, 0, BEATS,     1, 1};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0, 2, 0, 2 * BEATS, 2, 2};
    tbl[2] = '{32'hA5A5_A5A5, 32'h0, 1, 1, BEATS,     1, 1};
    tbl[3] = '{32'h0000_0007, 32'h0000_0003, 2, 0, 2 * BEATS, 2, 2};
    tbl[4] = '{32'h1357_9BDF, 32'hECA8_6420, 2, 1, 2 * BEATS, 2, 2};

    // Reset held three cycles with data already waiting in the FIFO.
    reset     = 1'b1;
    ser_ready = 1'b0;
    @(posedge clk);
    #1;
    push_word(32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      check("rst_valid", {31'd0, ser_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("first_pop", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    check("fetch_busy", {31'd0, busy}, 32'd1);
    check("fetch_valid", {31'd0, ser_valid}, 32'd0);
    @(negedge clk);
    check("first_bit_valid", {31'd0, ser_valid}, 32'd1);
    check("first_bit_data", {31'd0, ser_data}, 32'd1);
    $display("reset/latency sequence done");
    wait_hs(BEATS, 0, 200);
    wait_idle(50);

    for (int t = 0; t < 5; t++) begin
      base_hs  = hs_cnt;
      base_rd  = rd_pulses;
      base_ral = rd_at_last;
      base_last = last_seen;
      push_word(tbl[t].w0);
      if (tbl[t].nwords == 2) push_word(tbl[t].w1);
      wait_hs(base_hs + tbl[t].exp_hs, tbl[t].mode, 1000);
      wait_idle(50);
      check("rd_pulses", rd_pulses - base_rd, tbl[t].exp_rd);
      check("lasts", last_seen - base_last, tbl[t].exp_lasts);
      check("prefetch_at_last", rd_at_last - base_ral, tbl[t].nwords - 1);
      if (tbl[t].nwords == 2) check("word_gap", last_gap, 1);
      $display("vector %0d: words %08h/%08h mode %0d handshakes %0d", t,
               tbl[t].w0, tbl[t].w1, tbl[t].mode, hs_cnt - base_hs);
    end

    // Reset after the 10th bit discards the rest of the word.
    base_hs   = hs_cnt;
    base_last = last_seen;
    push_word(32'h1234_5678);
    wait_hs(base_hs + 10, 0, 200);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_valid", {31'd0, ser_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    check("abort_no_last", last_seen - base_last, 0);
    push_word(32'hC000_0003);
    wait_hs(hs_cnt + BEATS, 0, 200);
    wait_idle(50);
    check("after_abort_last", last_seen - base_last, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("reset-abort sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
